anubis_job_ctrl: RTL and testbench

//  Sequencer between requesters and one anubis core. Accepts a {key, block, encrypt} job
//  on a valid/ready port and latches the operands. Restarts the core by pulsing its

---
 rtl/anubis_ctrl_pkg.sv | 17 +
 rtl/anubis_end_edge.sv | 30 +++
 rtl/anubis_job_ctrl.sv | 147 ++++++++++++++
 tb/tb_anubis_job_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/anubis_ctrl_pkg.sv
// Shared definitions for the anubis job controller.
//   - Block and key widths of the anubis core interface.
//   - FSM state encodings, kept as plain 2-bit localparams so the encoding
//     stays fixed and visible in waveforms and any legacy tooling.
package anubis_ctrl_pkg;

  localparam int ANUBIS_BLK_W = 128;
  localparam int ANUBIS_KEY_W = 128;

  typedef logic [1:0] ctrl_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/anubis_end_edge.sv
// Registered rising-edge detector for the core end flag.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear of the stored previous sample
//   d     in  level input (core end flag)
//   rise  out d high now and low (or cleared) on the previous cycle
module anubis_end_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (clr) begin
      prev <= 1'b0;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/anubis_job_ctrl.sv
// Job sequencer in front of a single anubis core. Accepts one
// {key, block, encrypt} job, restarts the core with a reset pulse, waits for
// a fresh rising edge of the core end flag and returns the cipher text on a
// valid/ready result port.
//
// Build option: define ANUBIS_CTRL_WATCHDOG_EN to add a RUN-state watchdog
// that aborts a job after TIMEOUT_CYCLES with out_err=1 and out_data=0.
//
// Ports:
//   clk, reset                    clock, async active-low reset
//   in_valid/in_ready             job handshake
//   in_encrypt, in_key, in_data   job operands
//   core_reset                    active-high core restart / hold
//   core_encrypt/key/plain        latched operands to the core
//   core_cipher, core_end         core result and end flag
//   out_valid/out_ready           result handshake
//   out_data, out_err             result block, watchdog abort flag
//
// state | meaning
// IDLE  | core held in reset, waiting for a job
// START | core held in reset for START_CYCLES after accept
// RUN   | core released, waiting for a fresh end_flag rising edge
// DONE  | result presented, core held in reset until consumed
module anubis_job_ctrl
  import anubis_ctrl_pkg::*;
#(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_encrypt,
  input  logic [ANUBIS_KEY_W-1:0] in_key,
  input  logic [ANUBIS_BLK_W-1:0] in_data,
  output logic                    core_reset,
  output logic                    core_encrypt,
  output logic [ANUBIS_KEY_W-1:0] core_key,
  output logic [ANUBIS_BLK_W-1:0] core_plain,
  input  logic [ANUBIS_BLK_W-1:0] core_cipher,
  input  logic                    core_end,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ANUBIS_BLK_W-1:0] out_data,
  output logic                    out_err
);

  if (START_CYCLES < 1 || START_CYCLES > 2**CNT_W || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 2**CNT_W) begin : g_bad_param
    $error("anubis_job_ctrl: counter parameters out of range");
  end

  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);

  ctrl_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             end_rise;
  logic             end_clr;

  // The previous end sample is cleared while idle/done so nothing from an
  // older job survives, but it tracks core_end through START. A flag that is
  // already high when RUN begins therefore does not count as an edge.
  assign end_clr = (state == ST_IDLE) || (state == ST_DONE);

  anubis_end_edge u_end_edge (
    .clk   (clk),
    .rst_n (reset),
    .clr   (end_clr),
    .d     (core_end),
    .rise  (end_rise)
  );

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign core_reset = (state != ST_RUN);

`ifdef ANUBIS_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic err_q;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      core_encrypt <= 1'b1;
      core_key     <= '0;
      core_plain   <= '0;
      out_data     <= '0;
`ifdef ANUBIS_CTRL_WATCHDOG_EN
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            core_encrypt <= in_encrypt;
            core_key     <= in_key;
            core_plain   <= in_data;
            cnt          <= START_LOAD;
            state        <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            state <= ST_RUN;
`ifdef ANUBIS_CTRL_WATCHDOG_EN
            cnt   <= TIMEOUT_LOAD;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (end_rise) begin
            out_data <= core_cipher;
            state    <= ST_DONE;
          end
`ifdef ANUBIS_CTRL_WATCHDOG_EN
          else if (cnt == '0) begin
            out_data <= '0;
            err_q    <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
`ifdef ANUBIS_CTRL_WATCHDOG_EN
            err_q <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_job_ctrl.sv
module tb_anubis_job_ctrl;

  localparam int N_LAT = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_encrypt;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         core_reset;
  logic         core_encrypt;
  logic [127:0] core_key;
  logic [127:0] core_plain;
  logic [127:0] core_cipher;
  logic         core_end = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;

  int checks   = 0;
  int failures = 0;

  bit       stale_hold = 1'b0;
  bit       never_end  = 1'b0;
  logic [7:0] mcnt = 8'd0;

  always #5 clk = ~clk;

  anubis_job_ctrl #(
    .START_CYCLES   (2),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_encrypt   (in_encrypt),
    .in_key       (in_key),
    .in_data      (in_data),
    .core_reset   (core_reset),
    .core_encrypt (core_encrypt),
    .core_key     (core_key),
    .core_plain   (core_plain),
    .core_cipher  (core_cipher),
    .core_end     (core_end),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err)
  );

  // Behavioural core: end_flag high N_LAT cycles after core_reset falls.
  assign core_cipher = core_key ^ core_plain ^ {128{~core_encrypt}};

  always @(posedge clk) begin
    if (core_reset) begin
      mcnt     <= 8'd0;
      core_end <= stale_hold;
    end else begin
      if (mcnt != 8'hff) mcnt <= mcnt + 8'd1;
      core_end <= !never_end &&
                  ((mcnt >= 8'(N_LAT - 1)) || (stale_hold && mcnt < 8'd3));
    end
  end

  function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] d,
                                         input bit e);
    return k ^ d ^ (e ? 128'h0 : {128{1'b1}});
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic offer(input logic [127:0] k, input logic [127:0] d, input bit e,
                       input bit hold, output bit ok);
    in_key = k; in_data = d; in_encrypt = e; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_run(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!core_reset) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_valid(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_encrypt = 1'b0; in_key = '0; in_data = '0;
    out_ready = 1'b1;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (core_key !== 128'h0 || core_plain !== 128'h0) begin failures++; $display("FAIL rst_core_ops key=%h plain=%h exp=0", core_key, core_plain); end
    checks++; if (core_encrypt !== 1'b1) begin failures++; $display("FAIL rst_core_encrypt got=%b exp=1", core_encrypt); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int n;
    out_ready = 1'b1;
    offer(128'h0, 128'h0, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=accept"); end
    wait_run(n, ok);
    checks++; if (!ok || n != 2) begin failures++; $display("FAIL single_start_len got=%0d ok=%0d exp=2", n, ok); end
    wait_valid(n, ok);
    checks++; if (!ok || n != N_LAT + 1) begin failures++; $display("FAIL single_latency got=%0d ok=%0d exp=%0d", n, ok, N_LAT + 1); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL single_data got=%h exp=0", out_data); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", out_err); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL single_release valid=%b ready=%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    bit ok; bit rdy_bad; bit got;
    logic [127:0] k, d, exp;
    bit e;
    k = 128'h0123456789abcdef_fedcba9876543210;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      d = 128'(j + 1);
      e = (j != 1);
      exp = model(k, d, e);
      offer(k, d, e, 1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_accept job=%0d got=timeout exp=accept", j); end
      rdy_bad = 1'b0; got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (in_ready) rdy_bad = 1'b1;
        if (out_valid) begin got = 1'b1; break; end
        @(negedge clk);
      end
      checks++; if (!got) begin failures++; $display("FAIL b2b_result job=%0d got=timeout exp=out_valid", j); end
      checks++; if (rdy_bad) begin failures++; $display("FAIL b2b_in_ready job=%0d got=high_while_busy exp=low", j); end
      checks++; if (out_data !== exp) begin failures++; $display("FAIL b2b_data job=%0d got=%h exp=%h", j, out_data, exp); end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok; int n;
    logic [127:0] k, d, exp;
    k = 128'h00000000_11111111_22222222_33333333;
    d = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    exp = model(k, d, 1'b1);
    out_ready = 1'b0;
    offer(k, d, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_accept got=timeout exp=accept"); end
    wait_valid(n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_result got=timeout exp=out_valid"); end
    in_key = 128'h5; in_data = 128'h7; in_encrypt = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== exp) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, out_data, exp); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (core_plain !== d) begin failures++; $display("FAIL bp_no_accept cyc=%0d plain=%h exp=%h", i, core_plain, d); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b ready=%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_stale_end();
    bit ok; int n;
    logic [127:0] k, d, exp;
    k = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;
    d = 128'h12345678_9abcdef0_0fedcba9_87654321;
    exp = model(k, d, 1'b0);
    out_ready = 1'b1;
    stale_hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    offer(k, d, 1'b0, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stale_accept got=timeout exp=accept"); end
    wait_run(n, ok);
    checks++; if (!ok || n != 2) begin failures++; $display("FAIL stale_start_len got=%0d ok=%0d exp=2", n, ok); end
    wait_valid(n, ok);
    checks++; if (!ok || n != N_LAT + 1) begin failures++; $display("FAIL stale_latency got=%0d ok=%0d exp=%0d", n, ok, N_LAT + 1); end
    checks++; if (out_data !== exp) begin failures++; $display("FAIL stale_data got=%h exp=%h", out_data, exp); end
    stale_hold = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit ok; int n;
    logic [127:0] k, d, exp;
    out_ready = 1'b1;
    offer(128'haaaa, 128'h5555, 1'b0, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_accept got=timeout exp=accept"); end
    wait_run(n, ok);
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || core_reset !== 1'b1) begin failures++; $display("FAIL mid_rst_ctrl ready=%b core_reset=%b exp=1/1", in_ready, core_reset); end
    checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin failures++; $display("FAIL mid_rst_out valid=%b err=%b exp=0/0", out_valid, out_err); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", out_data); end
    checks++; if (core_key !== 128'h0 || core_plain !== 128'h0 || core_encrypt !== 1'b1) begin failures++; $display("FAIL mid_rst_ops key=%h plain=%h enc=%b exp=0/0/1", core_key, core_plain, core_encrypt); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    k = 128'h1; d = 128'h80000000_00000000_00000000_00000000;
    exp = model(k, d, 1'b1);
    offer(k, d, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_fresh_accept got=timeout exp=accept"); end
    wait_run(n, ok);
    wait_valid(n, ok);
    checks++; if (!ok || n != N_LAT + 1) begin failures++; $display("FAIL mid_fresh_latency got=%0d ok=%0d exp=%0d", n, ok, N_LAT + 1); end
    checks++; if (out_data !== exp) begin failures++; $display("FAIL mid_fresh_data got=%h exp=%h", out_data, exp); end
    @(negedge clk);
  endtask

`ifdef ANUBIS_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok; int n;
    out_ready = 1'b1;
    never_end = 1'b1;
    offer(128'h77, 128'h99, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wd_accept got=timeout exp=accept"); end
    wait_run(n, ok);
    wait_valid(n, ok);
    checks++; if (!ok || n != 16) begin failures++; $display("FAIL wd_latency got=%0d ok=%0d exp=16", n, ok); end
    checks++; if (out_err !== 1'b1) begin failures++; $display("FAIL wd_err got=%b exp=1", out_err); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL wd_data got=%h exp=0", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin failures++; $display("FAIL wd_clear valid=%b err=%b exp=0/0", out_valid, out_err); end
    never_end = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stale_end();
    test_reset_mid_run();
`ifdef ANUBIS_CTRL_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
